// File: rtl/motor_pin_matrix.sv
// motor_pin_matrix: run-time programmable registered crossbar from motor drive sources to header pins.
// Every remap forces the target pin driven-low for DEAD_CYCLES before the new route takes over.
module motor_pin_matrix #(
  parameter int NUM_SRC     = 32,
  parameter int NUM_PIN     = 52,
  parameter int DEAD_CYCLES = 4,
  localparam int SEL_W = $clog2(NUM_SRC + 1),
  localparam int PIN_W = $clog2(NUM_PIN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic               estop,
  input  logic               cfg_wr,
  input  logic [PIN_W-1:0]   cfg_pin,
  input  logic [SEL_W-1:0]   cfg_sel,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic [NUM_PIN-1:0] pin_out,
  output logic [NUM_PIN-1:0] pin_oe
);
  typedef enum logic [1:0] {IDLE, DEAD, APPLY} state_t;
  state_t             state;
  logic [7:0]         cnt;
  logic [PIN_W-1:0]   pin_lat;
  logic [SEL_W-1:0]   sel_lat;
  logic [SEL_W-1:0]   route [NUM_PIN];
  logic [NUM_PIN-1:0] nxt_out, nxt_oe;
  logic [NUM_SRC:0]   src_pad;
  logic               valid;
  assign src_pad = {src_in, 1'b0};
  assign valid = ({1'b0, cfg_pin} < (PIN_W + 1)'(NUM_PIN)) && ({1'b0, cfg_sel} <= (SEL_W + 1)'(NUM_SRC));
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pin_lat   <= '0;
      sel_lat   <= '0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      for (int i = 0; i < NUM_PIN; i++) route[i] <= '0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE:
          if (cfg_wr && valid) begin
            pin_lat   <= cfg_pin;
            sel_lat   <= cfg_sel;
            cnt       <= 8'(DEAD_CYCLES);
            state     <= DEAD;
            cfg_ready <= 1'b0;
          end else if (cfg_wr) cfg_err <= 1'b1;
        DEAD: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= APPLY;
        end
        APPLY: begin
          route[pin_lat] <= sel_lat;
          state          <= IDLE;
          cfg_ready      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  // During APPLY the latched selector already drives the pin, so the new source appears the same edge the route is written.
  for (genvar g = 0; g < NUM_PIN; g++) begin : g_pin
    logic [SEL_W-1:0] sel;
    logic             dead;
    assign dead       = (state == DEAD) && (pin_lat == PIN_W'(g));
    assign sel        = (state == APPLY && pin_lat == PIN_W'(g)) ? sel_lat : route[g];
    assign nxt_oe[g]  = dead || (sel != '0);
    assign nxt_out[g] = !dead && !estop && src_pad[sel];
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pin_out <= '0;
      pin_oe  <= '0;
    end else begin
      pin_out <= nxt_out;
      pin_oe  <= nxt_oe;
    end
endmodule

// File: tb/tb_motor_pin_matrix.sv
// tb_motor_pin_matrix: randomized scoreboard bench; a pending-remap model predicts every cycle's outputs,
// a monitor compares them against the DUT one cycle at a time.
module tb_motor_pin_matrix;
  localparam int NS = 32, NP = 52, D = 4;
  logic          clock = 0, reset = 1, estop = 0, cfg_wr = 0;
  logic [NS-1:0] src_in = '0;
  logic [5:0]    cfg_pin = '0, cfg_sel = '0;
  logic          cfg_ready, cfg_err;
  logic [NP-1:0] pin_out, pin_oe;
  typedef struct packed {logic [NP-1:0] out; logic [NP-1:0] oe; logic ready; logic err;} exp_t;
  exp_t q[$];
  int   checks = 0, failures = 0, edge_n = 0;
  int   m_route[NP];
  bit   m_busy = 0, rst_v = 1, est_v = 0;
  int   m_pin, m_sel, m_phase;
  always #5 clock = ~clock;
  motor_pin_matrix #(.NUM_SRC(NS), .NUM_PIN(NP), .DEAD_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .src_in(src_in), .estop(estop), .cfg_wr(cfg_wr),
    .cfg_pin(cfg_pin), .cfg_sel(cfg_sel), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .pin_out(pin_out), .pin_oe(pin_oe));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%h expected=%h", name, edge_n, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clock);
    #1;
    edge_n++;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pin_out", 64'(pin_out), 64'(e.out));
      chk("pin_oe", 64'(pin_oe), 64'(e.oe));
      chk("cfg_ready", 64'(cfg_ready), 64'(e.ready));
      chk("cfg_err", 64'(cfg_err), 64'(e.err));
    end
  end
  // Drives one cycle of stimulus and predicts the outputs seen after the following edge.
  task automatic step(input bit wr, input int pin, input int sel);
    exp_t e;
    bit   forced;
    @(negedge clock);
    src_in  = $urandom;
    estop   = est_v;
    reset   = rst_v;
    cfg_wr  = wr;
    cfg_pin = 6'(pin);
    cfg_sel = 6'(sel);
    e = '0;
    if (rst_v) begin
      foreach (m_route[p]) m_route[p] = 0;
      m_busy  = 0;
      e.ready = 1;
    end else begin
      if (!m_busy) begin
        if (wr && pin < NP && sel <= NS) begin
          m_busy = 1; m_pin = pin; m_sel = sel; m_phase = 0;
        end else if (wr) e.err = 1;
      end else begin
        m_phase++;
        if (m_phase > D) begin
          m_route[m_pin] = m_sel;
          m_busy = 0;
        end
      end
      forced = m_busy && m_phase >= 1;
      for (int p = 0; p < NP; p++)
        if (forced && p == m_pin) e.oe[p] = 1;
        else if (m_route[p] != 0) begin
          e.oe[p]  = 1;
          e.out[p] = !est_v && src_in[m_route[p]-1];
        end
      e.ready = !m_busy;
    end
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask
  initial begin
    int r;
    rst_v = 1;
    idle(3);
    rst_v = 0;
    idle(6);
    step(1, 0, 1);
    idle(8);
    step(1, 3, 4);
    idle(5);
    step(1, 26, 25);
    idle(5);
    step(1, 3, 10);
    idle(7);
    step(1, 52, 1);
    idle(1);
    step(1, 0, 33);
    idle(1);
    step(1, 7, 2);
    step(1, 8, 3);
    step(1, 60, 40);
    idle(4);
    for (int i = 0; i < 6; i++) begin
      step(1, 40 + i, 11 + i);
      idle(D);
    end
    est_v = 1;
    idle(10);
    est_v = 0;
    idle(3);
    step(1, 5, 7);
    idle(1);
    rst_v = 1;
    step(0, 0, 0);
    #1;
    chk("reset_now_oe", 64'(pin_oe), 64'(0));
    chk("reset_now_out", 64'(pin_out), 64'(0));
    chk("reset_now_ready", 64'(cfg_ready), 64'(1));
    idle(1);
    rst_v = 0;
    idle(3);
    repeat (1500) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 39) == 0) est_v = !est_v;
      rst_v = ($urandom_range(0, 399) == 0);
      step(r < 4,
           (r == 0) ? $urandom_range(0, 63) : $urandom_range(0, NP - 1),
           (r == 1) ? $urandom_range(0, 63) : $urandom_range(0, NS));
    end
    rst_v = 0;
    est_v = 0;
    idle(3);
    @(posedge clock);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
